// File: rtl/st_packet_arbiter_2to1.sv
// Packet-granular 2:1 Avalon-ST arbiter with a registered output stage and a sticky framing-error flag.
// Build option: define STREAM_ARB_FIXED_PRIO_EN for fixed priority (in0 wins ties); the default is round-robin.
module st_packet_arbiter_2to1 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_startofpacket,
    input  logic              in0_endofpacket,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_startofpacket,
    input  logic              in1_endofpacket,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic              out_channel,
    input  logic              err_clear,
    output logic              err_sticky
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY0 = 2'd1,
        S_BUSY1 = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_first;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_sop;
    logic                r_out_eop;
    logic                r_out_channel;
    logic                r_err;
`ifndef STREAM_ARB_FIXED_PRIO_EN
    logic                r_last_grant;
`endif

    logic                w_elig0;
    logic                w_elig1;
    logic                w_pick1;
    logic                w_slot_free;
    logic                w_sel1;
    logic                w_acc;
    logic [DATA_W-1:0]   w_beat_data;
    logic                w_beat_sop;
    logic                w_beat_eop;
    logic                w_drop_err;
    logic                w_sop_err;

    assign w_elig0     = in0_valid & in0_startofpacket;
    assign w_elig1     = in1_valid & in1_startofpacket;
    assign w_slot_free = !r_out_valid | out_ready;

`ifdef STREAM_ARB_FIXED_PRIO_EN
    assign w_pick1 = w_elig1 & !w_elig0;
`else
    assign w_pick1 = w_elig1 & (!w_elig0 | !r_last_grant);
`endif

    // In IDLE a source showing sop is held off while arbitration happens;
    // anything without sop is swallowed so a broken source cannot wedge the arbiter.
    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                in0_ready = !in0_startofpacket;
                in1_ready = !in1_startofpacket;
            end
            S_BUSY0: in0_ready = w_slot_free;
            S_BUSY1: in1_ready = w_slot_free;
            default: ;
        endcase
        if (!reset_n) begin
            in0_ready = 1'b0;
            in1_ready = 1'b0;
        end
    end

    assign w_sel1      = (r_state == S_BUSY1);
    assign w_acc       = ((r_state == S_BUSY0) & in0_valid & in0_ready) |
                         ((r_state == S_BUSY1) & in1_valid & in1_ready);
    assign w_beat_data = w_sel1 ? in1_data          : in0_data;
    assign w_beat_sop  = w_sel1 ? in1_startofpacket : in0_startofpacket;
    assign w_beat_eop  = w_sel1 ? in1_endofpacket   : in0_endofpacket;

    assign w_drop_err  = (r_state == S_IDLE) &
                         ((in0_valid & !in0_startofpacket) | (in1_valid & !in1_startofpacket));
    assign w_sop_err   = w_acc & w_beat_sop & !r_first;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_first       <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_out_channel <= 1'b0;
            r_err         <= 1'b0;
`ifndef STREAM_ARB_FIXED_PRIO_EN
            r_last_grant  <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_elig0 | w_elig1) begin
                        r_state <= w_pick1 ? S_BUSY1 : S_BUSY0;
                        r_first <= 1'b1;
`ifndef STREAM_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_pick1;
`endif
                    end
                end
                S_BUSY0, S_BUSY1: begin
                    if (w_acc) begin
                        r_first <= 1'b0;
                        if (w_beat_eop) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_acc) begin
                r_out_valid   <= 1'b1;
                r_out_data    <= w_beat_data;
                r_out_sop     <= w_beat_sop;
                r_out_eop     <= w_beat_eop;
                r_out_channel <= w_sel1;
            end else if (out_ready) begin
                r_out_valid   <= 1'b0;
            end

            // A fresh error outranks a simultaneous clear.
            if (w_drop_err | w_sop_err) begin
                r_err <= 1'b1;
            end else if (err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_channel       = r_out_channel;
    assign err_sticky        = r_err;

endmodule

// File: tb/tb_st_packet_arbiter_2to1.sv
// Scoreboard bench for st_packet_arbiter_2to1: expected beats are queued as stimulus is issued
// and popped by a negedge monitor as the sink accepts them.
module tb_st_packet_arbiter_2to1;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       ch;
    } beat_t;

    logic       clk;
    logic       reset_n;
    logic       v [2];
    logic       s [2];
    logic       e [2];
    logic [7:0] d [2];
    logic       in0_ready, in1_ready;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_startofpacket, out_endofpacket, out_channel;
    logic       err_clear, err_sticky;

    st_packet_arbiter_2to1 #(.DATA_W(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in0_valid         (v[0]),
        .in0_ready         (in0_ready),
        .in0_data          (d[0]),
        .in0_startofpacket (s[0]),
        .in0_endofpacket   (e[0]),
        .in1_valid         (v[1]),
        .in1_ready         (in1_ready),
        .in1_data          (d[1]),
        .in1_startofpacket (s[1]),
        .in1_endofpacket   (e[1]),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_channel       (out_channel),
        .err_clear         (err_clear),
        .err_sticky        (err_sticky)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    beat_t sb[$];
    logic  mon_en    = 1'b0;
    logic  check_gap = 1'b0;
    logic  bp_check  = 1'b0;
    logic  prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int    last_sop_cyc = -1;
    int    last_eop_cyc = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, sb size=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    // Sink-side monitor: scoreboard pop, hold-stability, backpressure and bubble checks.
    always @(negedge clk) begin
        beat_t exp_b;
        if (reset_n && mon_en) begin
            if (prev_stall) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h", out_valid, out_data, prev_data);
                end
            end
            if (bp_check && out_valid && !out_ready) begin
                n_tests++;
                if (in1_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_ready: in1_ready=%b required 0 while stalled", in1_ready);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: data=%h sop=%b eop=%b ch=%b with empty scoreboard",
                             out_data, out_startofpacket, out_endofpacket, out_channel);
                end else begin
                    exp_b = sb.pop_front();
                    if ({out_data, out_startofpacket, out_endofpacket, out_channel} !== exp_b) begin
                        n_fail++;
                        $display("FAIL beat: got d=%h sop=%b eop=%b ch=%b required d=%h sop=%b eop=%b ch=%b",
                                 out_data, out_startofpacket, out_endofpacket, out_channel,
                                 exp_b.d, exp_b.sop, exp_b.eop, exp_b.ch);
                    end else begin
                        $display("[TB] beat d=%h sop=%b eop=%b ch=%b ok", out_data, out_startofpacket,
                                 out_endofpacket, out_channel);
                    end
                    if (out_startofpacket) begin
                        if (check_gap && last_eop_cyc >= 0) begin
                            n_tests++;
                            if (cyc - last_eop_cyc != 2) begin
                                n_fail++;
                                $display("FAIL bubble: packet gap=%0d cycles required 2", cyc - last_eop_cyc);
                            end
                        end
                        last_sop_cyc = cyc;
                    end
                    if (out_endofpacket) last_eop_cyc = cyc;
                end
            end
        end
        prev_stall = reset_n && out_valid && !out_ready;
        prev_data  = out_data;
    end

    function automatic logic rdy(input int src);
        return (src != 0) ? in1_ready : in0_ready;
    endfunction

    task automatic push_pkt(input int src, input int n, input logic [7:0] base,
                            input int step, input int bad);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d   = base + 8'(i * step);
            b.sop = (i == 0) || (i == bad);
            b.eop = (i == n - 1);
            b.ch  = (src != 0);
            sb.push_back(b);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the last beat.
    task automatic send_pkt(input int src, input int n, input logic [7:0] base,
                            input int step, input int bad);
        int  t;
        logic acc;
        for (int i = 0; i < n; i++) begin
            v[src] = 1'b1;
            d[src] = base + 8'(i * step);
            s[src] = (i == 0) || (i == bad);
            e[src] = (i == n - 1);
            t   = 0;
            acc = 1'b0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = rdy(src);
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: src=%0d beat=%0d ready=0 required 1 within 200 cycles", src, i);
                break;
            end
        end
        v[src] = 1'b0;
        s[src] = 1'b0;
        e[src] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d beats outstanding required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, err_sticky,
             in0_ready, in1_ready} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_vals: valid=%b data=%h sop=%b eop=%b ch=%b err=%b r0=%b r1=%b required all 0",
                     out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, err_sticky,
                     in0_ready, in1_ready);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        $display("[TB] test_reset done");
    endtask

    task automatic test_back_to_back;
        check_gap    = 1'b1;
        last_eop_cyc = -1;
`ifdef STREAM_ARB_FIXED_PRIO_EN
        push_pkt(0, 2, 8'h10, 1, -1);
        push_pkt(0, 2, 8'h20, 1, -1);
        push_pkt(1, 2, 8'h80, 1, -1);
        push_pkt(1, 2, 8'h90, 1, -1);
`else
        push_pkt(0, 2, 8'h10, 1, -1);
        push_pkt(1, 2, 8'h80, 1, -1);
        push_pkt(0, 2, 8'h20, 1, -1);
        push_pkt(1, 2, 8'h90, 1, -1);
`endif
        fork
            begin
                send_pkt(0, 2, 8'h10, 1, -1);
                send_pkt(0, 2, 8'h20, 1, -1);
            end
            begin
                send_pkt(1, 2, 8'h80, 1, -1);
                send_pkt(1, 2, 8'h90, 1, -1);
            end
        join
        wait_drain("back_to_back");
        check_gap = 1'b0;
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_basic;
        int t0;
        t0 = cyc;
        push_pkt(0, 3, 8'h11, 8'h11, -1);
        send_pkt(0, 3, 8'h11, 8'h11, -1);
        wait_drain("basic");
        n_tests++;
        if (last_sop_cyc - t0 != 2) begin
            n_fail++;
            $display("FAIL first_latency: %0d cycles required 2", last_sop_cyc - t0);
        end
        n_tests++;
        if (last_eop_cyc - last_sop_cyc != 2) begin
            n_fail++;
            $display("FAIL burst_span: sop-to-eop %0d cycles required 2", last_eop_cyc - last_sop_cyc);
        end
        n_tests++;
        if (err_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_err: err_sticky=%b required 0", err_sticky);
        end
        $display("[TB] test_basic done");
    endtask

    task automatic test_backpressure;
        logic [3:0] pat;
        logic       done;
        pat      = 4'b1001;
        done     = 1'b0;
        bp_check = 1'b1;
        push_pkt(1, 4, 8'hA0, 1, -1);
        fork
            begin
                send_pkt(1, 4, 8'hA0, 1, -1);
                done = 1'b1;
            end
            begin
                int k;
                k = 0;
                while (!done) begin
                    out_ready = pat[k % 4];
                    k++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("backpressure");
        bp_check = 1'b0;
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_drop_err;
        v[0] = 1'b1;
        s[0] = 1'b0;
        e[0] = 1'b0;
        d[0] = 8'h55;
        @(negedge clk);
        n_tests++;
        if (in0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_ready: in0_ready=%b required 1", in0_ready);
        end
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        n_tests++;
        if (err_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_err: err_sticky=%b required 1", err_sticky);
        end
        repeat (2) begin
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_out: out_valid=%b required 0", out_valid);
            end
            @(posedge clk);
            #1;
        end
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        n_tests++;
        if (err_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err_sticky=%b required 0", err_sticky);
        end
        v[1] = 1'b1;
        s[1] = 1'b0;
        d[1] = 8'h66;
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        v[1] = 1'b0;
        err_clear = 1'b0;
        n_tests++;
        if (err_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL err_priority: err_sticky=%b required 1", err_sticky);
        end
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        $display("[TB] test_drop_err done");
    endtask

    task automatic test_sop_err;
        push_pkt(0, 3, 8'h40, 1, 1);
        send_pkt(0, 3, 8'h40, 1, 1);
        wait_drain("sop_err");
        n_tests++;
        if (err_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL sop_err: err_sticky=%b required 1", err_sticky);
        end
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        $display("[TB] test_sop_err done");
    endtask

    task automatic test_single_beat;
        push_pkt(1, 1, 8'h7E, 1, -1);
        push_pkt(0, 2, 8'h31, 1, -1);
        send_pkt(1, 1, 8'h7E, 1, -1);
        send_pkt(0, 2, 8'h31, 1, -1);
        wait_drain("single_beat");
        n_tests++;
        if (err_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL single_err: err_sticky=%b required 0", err_sticky);
        end
        $display("[TB] test_single_beat done");
    endtask

    task automatic test_reset_mid;
        mon_en = 1'b0;
        v[0] = 1'b1;
        s[0] = 1'b1;
        e[0] = 1'b0;
        d[0] = 8'h01;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        s[0] = 1'b0;
        d[0] = 8'h02;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h01) begin
            n_fail++;
            $display("FAIL mid_pre: valid=%b data=%h required valid=1 data=01", out_valid, out_data);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, err_sticky,
             in0_ready, in1_ready} !== 15'h0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b data=%h sop=%b eop=%b ch=%b err=%b r0=%b r1=%b required all 0",
                     out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, err_sticky,
                     in0_ready, in1_ready);
        end
        v[0] = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        push_pkt(1, 3, 8'hC1, 1, -1);
        send_pkt(1, 3, 8'hC1, 1, -1);
        wait_drain("reset_mid");
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        reset_n   = 1'b1;
        out_ready = 1'b1;
        err_clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0;
            s[i] = 1'b0;
            e[i] = 1'b0;
            d[i] = 8'h00;
        end
        test_reset();
        test_back_to_back();
        test_basic();
        test_backpressure();
        test_drop_err();
        test_sop_err();
        test_single_beat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/st_packet_arbiter_2to1.md
# st_packet_arbiter_2to1

Packet-granular 2:1 arbiter that shares one 8-bit Avalon-ST packet sink between two packet sources. It sits upstream of the data format adapter in the c2h_mandelbrot streaming path. Packets are never interleaved: a grant is held from start-of-packet to end-of-packet. The output is registered, and malformed framing is detected and reported through a sticky error flag.

## Interface
Parameters:
- DATA_W, 8, data width of every stream port.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- in0_valid / in1_valid  in  1  source beat valid.
- in0_ready / in1_ready  out  1  beat accepted when valid and ready are both high.
- in0_data / in1_data  in  DATA_W  beat data.
- in0_startofpacket / in1_startofpacket  in  1  first beat of a packet.
- in0_endofpacket / in1_endofpacket  in  1  last beat of a packet.
- out_ready  in  1  sink ready.
- out_valid  out  1  registered beat valid.
- out_data  out  DATA_W  registered beat data.
- out_startofpacket, out_endofpacket  out  1  registered framing.
- out_channel  out  1  index of the source that produced the current output beat.
- err_clear  in  1  synchronous clear of err_sticky.
- err_sticky  out  1  framing error seen since the last clear.

## Operation
- Requester n is eligible when inN_valid=1 and inN_startofpacket=1.
- States:
  - IDLE: no grant.
  - BUSY0: grant to in0.
  - BUSY1: grant to in1.
- IDLE transitions:
  - One eligible requester: go to BUSYn on the next edge.
  - Both eligible: round-robin. Grant the requester that is not last_grant, then set last_grant to the winner.
- Handshake:
  - Granted source only: inN_ready = !out_valid | out_ready.
  - The non-granted source has ready held at 0.
- Output register:
  - Loads data, sop, eop and channel on each accepted beat.
  - out_valid is set on load and cleared when out_ready=1 and no new beat is loaded.
  - Output is never overwritten while out_valid=1 and out_ready=0.
- BUSYn to IDLE: on the edge where an accepted granted beat has endofpacket=1.
- Framing errors (each sets err_sticky on the next edge):
  - In IDLE, inN_valid=1 with startofpacket=0: inN_ready=1 and the beat is dropped. It never reaches the output.
  - In BUSYn, an accepted beat with startofpacket=1 that is not the first beat: the beat is passed through unchanged.
- A single beat with sop=1 and eop=1 is legal. It passes and returns to IDLE.
- err_clear=1 clears err_sticky. If err_clear and a new error occur in the same cycle, the error wins and err_sticky stays 1.

## Timing
- Reset values:
  - State IDLE, last_grant=1 (so in0 wins the first tie).
  - out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0.
  - err_sticky=0, in0_ready=0, in1_ready=0.
- Reset is asynchronous and may be asserted mid-packet. The partial packet is abandoned and the output beat is discarded. No recovery of the truncated packet is attempted.
- Latency:
  - The first beat appears on out_valid 2 cycles after eligibility: 1 cycle to arbitrate, 1 cycle for the register.
  - Later beats take 1 cycle.
- Throughput: 1 beat per cycle inside a packet while out_ready=1.
- Packet turnaround: the cycle after eop is accepted is IDLE, giving one bubble cycle between packets.
- inN_ready is combinational from out_ready and the state. No combinational path exists from inN_valid to inN_ready.

## Configuration
- STREAM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. in0 wins every tie, and last_grant is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then in0 only sends a 3-beat packet 0x11, 0x22, 0x33 with out_ready=1:
  - out_valid rises 2 cycles after sop and carries 0x11 (sop), 0x22, 0x33 (eop) on consecutive cycles.
  - out_channel=0 throughout, err_sticky=0.
- Both sources hold sop-valid continuously with 2-beat packets:
  - Grant order is in0, in1, in0, in1.
  - Exactly one bubble cycle between packets.
  - With STREAM_ARB_FIXED_PRIO_EN defined, every packet comes from in0.
- out_ready toggles 1,0,0,1 during an in1 packet of 0xA0..0xA3:
  - No beat is lost or duplicated.
  - out_data stays stable while out_ready=0.
  - in1_ready=0 whenever out_valid=1 and out_ready=0.
- In IDLE, in0 presents sop=0 with data 0x55:
  - in0_ready=1 and the beat is dropped; out_valid stays 0.
  - err_sticky=1 next cycle.
  - err_clear pulse returns err_sticky to 0.
- Single-beat packet (sop=eop=1, 0x7E) on in1 followed by an in0 packet:
  - Both are delivered with out_channel 1 then 0.
- reset_n asserted mid-packet on in0:
  - All outputs immediately read their reset values.
  - After release, a fresh in1 packet is granted and delivered intact.
